uart_tx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_tx_fifo_ctrl
// PURPOSE
//  Drains the TX byte FIFO into the UART transmit serializer, one frame at a time.
//  Issues FIFO pops and absorbs the FIFO's 1-cycle synchronous BRAM read latency.
//  Hands each byte to the TX engine with a start/busy handshake, then enforces an
//  optional inter-frame gap. Sits between the TX fifo instance and uart_tx.
// PARAMETERS
//  WIDTH       8   data width; must equal the FIFO WIDTH and the TX engine width
//  GAP_CYCLES  0   idle clk cycles inserted after each frame (0 = back-to-back)
//  CNT_WIDTH   16  width of the sent-frame counter
// PORTS
//  clk_i          in   1          system clock, all logic on rising edge
//  rst_i          in   1          synchronous, active-high reset
//  enable_i       in   1          1 = drain FIFO; 0 = stop after current frame
//  fifo_empty_i   in   1          FIFO empty flag
//  fifo_pop_o     out  1          FIFO pop strobe, one cycle per byte
//  fifo_data_i    in   WIDTH      FIFO read data, valid the cycle after pop
//  tx_start_o     out  1          one-cycle start strobe to the TX engine
//  tx_data_o      out  WIDTH      byte to transmit; registered, held until next load
//  tx_busy_i      in   1          TX engine busy (frame in progress)
//  active_o       out  1          1 whenever the FSM is not in IDLE
//  sent_count_o   out  CNT_WIDTH  frames started since reset; wraps modulo 2^CNT_WIDTH
//  cts_n_i        in   1          clear-to-send, active low (FLOW_CTRL_EN only)
// BEHAVIOUR
//  Interface: one clock (clk_i); reset rst_i is synchronous, active-high.
//  Reset: state=IDLE; fifo_pop_o=0, tx_start_o=0, tx_data_o=0, active_o=0,
//   sent_count_o=0, gap counter=0. Reset mid-frame drops any popped byte. Handshakes
//   already in flight are not completed or retracted.
//  FSM states: IDLE, FETCH, LOAD, WAIT_ACK, WAIT_DONE, GAP.
//  IDLE: when enable_i & ~fifo_empty_i & cts_ok, drive fifo_pop_o=1 (combinational,
//   this cycle only) and go to FETCH. Otherwise hold.
//  FETCH: fifo_data_i is valid. Register it into tx_data_o. Go to LOAD.
//  LOAD: if ~tx_busy_i, drive tx_start_o=1 for this cycle, increment sent_count_o,
//   and go to WAIT_ACK. If tx_busy_i=1, hold in LOAD with no strobe.
//  WAIT_ACK: stay until tx_busy_i=1, then go to WAIT_DONE.
//  WAIT_DONE: stay until tx_busy_i=0. Then go to GAP if GAP_CYCLES>0 and load the
//   gap counter with GAP_CYCLES-1; otherwise go to IDLE.
//  GAP: decrement the counter each cycle; go to IDLE the cycle the counter is 0.
//  Latency: pop at cycle N, tx_start_o at N+2 (TX idle). With GAP_CYCLES=0 the next
//   pop is 1 cycle after busy falls.
//  At most one byte is outstanding. fifo_pop_o is never asserted while fifo_empty_i=1
//   or outside IDLE.
//  enable_i is sampled only in IDLE. Deasserting it mid-frame completes the current
//   frame and gap, then the FSM parks in IDLE.
//  Gap counter width is $clog2(GAP_CYCLES+1), minimum 1. The sent counter wraps
//   silently from all-ones to 0.
//  FIFO emptying during a frame has no effect; the FSM returns to IDLE and waits.
//  active_o = (state != IDLE), registered from the state.
// CONFIGURATION
//  Macro: UART_TX_FLOW_CTRL_EN.
//  Defined: the cts_n_i port exists and passes through a 2-flop synchronizer that
//   resets to 1. cts_ok = ~synced cts_n_i, gating only the IDLE pop decision. A frame
//   in progress always completes.
//  Undefined: cts_n_i and the synchronizer are absent; cts_ok is tied to 1.
// TESTING
//  T1 basic: GAP=0; FIFO holds 0xA5; enable_i=1
//   -> pop at N, tx_start_o at N+2 with tx_data_o=0xA5, sent_count_o=1.
//  T2 burst: 3 bytes 0x01,0x02,0x03; TX model busy for 10 cycles after start
//   -> 3 starts in order, each pop 1 cycle after busy falls, sent_count_o=3, then IDLE.
//  T3 gap: GAP_CYCLES=4; 2 bytes queued
//   -> exactly 4 idle cycles between busy falling and the second pop.
//  T4 stall: tx_busy_i held 1 on entry to LOAD for 7 cycles
//   -> no tx_start_o until busy drops; then start with the correct data.
//  T5 enable/reset: enable_i=0 in WAIT_DONE -> frame finishes, no further pop with
//   FIFO non-empty. rst_i=1 in WAIT_ACK -> next cycle all outputs 0, state IDLE.
//  T6 flow ctrl (UART_TX_FLOW_CTRL_EN): cts_n_i=1 with FIFO non-empty -> no pop.
//   cts_n_i->0 -> pop exactly 2 cycles later (synchronizer delay). cts_n_i->1
//   mid-frame -> frame completes.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl.sv
// Drains the TX byte FIFO into the UART serializer one frame at a time, with optional inter-frame gap.
// Optional CTS flow control is compiled in with the UART_TX_FLOW_CTRL_EN macro.
//
// state     | meaning
// IDLE      | waiting for enable, data and clear-to-send; pops on exit
// FETCH     | FIFO read data valid, captured into tx_data_o
// LOAD      | waiting for TX engine idle, then strobes tx_start_o
// WAIT_ACK  | waiting for TX engine to raise busy
// WAIT_DONE | waiting for TX engine to finish the frame
// GAP       | counting down the inter-frame idle gap
module uart_tx_fifo_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_pop_o,
    input  logic [WIDTH-1:0]     fifo_data_i,
    output logic                 tx_start_o,
    output logic [WIDTH-1:0]     tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 active_o,
    output logic [CNT_WIDTH-1:0] sent_count_o
`ifdef UART_TX_FLOW_CTRL_EN
    ,
    input  logic                 cts_n_i
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pop_req;
    logic             start_req;
    logic             cts_ok;
    logic             active_r;

`ifdef UART_TX_FLOW_CTRL_EN
    // Idles at "not clear" so nothing is sent until CTS is seen asserted.
    logic [1:0] cts_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n_i};
        end
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        pop_req   = 1'b0;
        start_req = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && !fifo_empty_i && cts_ok) begin
                    pop_req   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                if (!tx_busy_i) begin
                    start_req = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy_i) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy_i) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are masked during reset so nothing leaks out while the FSM is forced to IDLE.
    assign fifo_pop_o = pop_req & ~rst_i;
    assign tx_start_o = start_req & ~rst_i;
    assign active_o   = active_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            active_r     <= 1'b0;
            tx_data_o    <= '0;
            sent_count_o <= '0;
            gap_cnt      <= '0;
        end else begin
            state    <= state_nxt;
            active_r <= (state_nxt != IDLE);
            if (state == FETCH) begin
                tx_data_o <= fifo_data_i;
            end
            if (start_req) begin
                sent_count_o <= sent_count_o + 1'b1;
            end
            if (state == WAIT_DONE && !tx_busy_i) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl: a back-to-back instance and a 4-cycle-gap instance
// with a 2-bit frame counter, each driven by a FIFO model and a TX engine model.
module tb_uart_tx_fifo_ctrl;

    typedef struct {
        logic [7:0] d;
        int         cnt;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, en0, empty0, busy0, en4, empty4, busy4;
    logic [7:0] data0, data4;
    logic       pop0, start0, active0, pop4, start4, active4;
    logic [7:0] txd0, txd4;
    logic [15:0] cnt0;
    logic [1:0]  cnt4;
`ifdef UART_TX_FLOW_CTRL_EN
    logic cts0, cts4;
`endif

    uart_tx_fifo_ctrl #(.WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .fifo_empty_i(empty0),
        .fifo_pop_o(pop0), .fifo_data_i(data0), .tx_start_o(start0), .tx_data_o(txd0),
        .tx_busy_i(busy0), .active_o(active0), .sent_count_o(cnt0)
`ifdef UART_TX_FLOW_CTRL_EN
        , .cts_n_i(cts0)
`endif
    );

    uart_tx_fifo_ctrl #(.WIDTH(8), .GAP_CYCLES(4), .CNT_WIDTH(2)) dut4 (
        .clk_i(clk), .rst_i(rst), .enable_i(en4), .fifo_empty_i(empty4),
        .fifo_pop_o(pop4), .fifo_data_i(data4), .tx_start_o(start4), .tx_data_o(txd4),
        .tx_busy_i(busy4), .active_o(active4), .sent_count_o(cnt4)
`ifdef UART_TX_FLOW_CTRL_EN
        , .cts_n_i(cts4)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] fifo_q0[$];
    logic [7:0] fifo_q4[$];
    exp_t exp0[$];
    exp_t exp4[$];
    int exp_cnt0 = 0, exp_cnt4 = 0;
    int stall0 = 0;
    int pops0 = 0, last_pop0 = 0, fall0 = -1;
    int last_pop4 = 0, fall4 = -1;
    bit chk_gap0 = 1'b0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push0(input logic [7:0] d, input int lat);
        fifo_q0.push_back(d);
        exp0.push_back('{d, exp_cnt0, lat});
        exp_cnt0++;
    endtask

    task automatic push4(input logic [7:0] d);
        fifo_q4.push_back(d);
        exp4.push_back('{d, exp_cnt4, 2});
        exp_cnt4 = (exp_cnt4 + 1) % 4;
    endtask

    // FIFO with registered read data plus a TX engine busy for 10 cycles per frame.
    task automatic model0();
        logic p, s;
        int bc;
        bc = 0;
        forever begin
            @(negedge clk);
            p = pop0;
            s = start0;
            @(posedge clk);
            #1;
            if (p && fifo_q0.size() > 0) data0 = fifo_q0.pop_front();
            if (p && stall0 > 0) begin
                bc = stall0;
                stall0 = 0;
            end
            if (s) bc = 10;
            if (bc > 0) begin
                busy0 = 1'b1;
                bc--;
            end else begin
                busy0 = 1'b0;
            end
            empty0 = (fifo_q0.size() == 0);
        end
    endtask

    task automatic model4();
        logic p, s;
        int bc;
        bc = 0;
        forever begin
            @(negedge clk);
            p = pop4;
            s = start4;
            @(posedge clk);
            #1;
            if (p && fifo_q4.size() > 0) data4 = fifo_q4.pop_front();
            if (s) bc = 10;
            if (bc > 0) begin
                busy4 = 1'b1;
                bc--;
            end else begin
                busy4 = 1'b0;
            end
            empty4 = (fifo_q4.size() == 0);
        end
    endtask

    task automatic monitor();
        logic bprev0, bprev4;
        exp_t e;
        bprev0 = 1'b0;
        bprev4 = 1'b0;
        forever begin
            @(negedge clk);
            if (bprev0 && !busy0) fall0 = cyc;
            bprev0 = busy0;
            if (bprev4 && !busy4) fall4 = cyc;
            bprev4 = busy4;
            if (pop0) begin
                check_eq("pop0_nonempty", empty0, 0);
                if (chk_gap0 && fall0 > last_pop0) check_eq("pop0_after_busy_fall", cyc - fall0, 1);
                last_pop0 = cyc;
                pops0++;
            end
            if (start0) begin
                if (exp0.size() == 0) begin
                    check_eq("start0_expected", exp0.size(), 1);
                end else begin
                    e = exp0.pop_front();
                    check_eq("start0_data", txd0, e.d);
                    check_eq("start0_count", cnt0, e.cnt);
                    check_eq("start0_latency", cyc - last_pop0, e.lat);
                end
            end
            if (pop4) begin
                check_eq("pop4_nonempty", empty4, 0);
                if (fall4 > last_pop4) check_eq("pop4_gap", cyc - fall4, 5);
                last_pop4 = cyc;
            end
            if (start4) begin
                if (exp4.size() == 0) begin
                    check_eq("start4_expected", exp4.size(), 1);
                end else begin
                    e = exp4.pop_front();
                    check_eq("start4_data", txd4, e.d);
                    check_eq("start4_count", cnt4, e.cnt);
                    check_eq("start4_latency", cyc - last_pop4, e.lat);
                end
            end
        end
    endtask

    task automatic wait_idle0(input int max);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            @(negedge clk);
            if (exp0.size() == 0 && !active0 && !busy0) done = 1'b1;
            n++;
        end
        check_eq("idle0_reached", done, 1);
    endtask

    task automatic wait_idle4(input int max);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            @(negedge clk);
            if (exp4.size() == 0 && !active4 && !busy4) done = 1'b1;
            n++;
        end
        check_eq("idle4_reached", done, 1);
    endtask

    task automatic wait_start0(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!start0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq("start0_seen", start0, 1);
    endtask

    initial begin
        int p;
        rst = 1'b1; en0 = 1'b0; en4 = 1'b0;
        empty0 = 1'b1; empty4 = 1'b1; busy0 = 1'b0; busy4 = 1'b0;
        data0 = '0; data4 = '0;
`ifdef UART_TX_FLOW_CTRL_EN
        cts0 = 1'b0; cts4 = 1'b0;
`endif
        fork
            model0();
            model4();
            monitor();
        join_none

        repeat (3) step();
        @(negedge clk);
        check_eq("rst_pop", pop0, 0);
        check_eq("rst_start", start0, 0);
        check_eq("rst_data", txd0, 0);
        check_eq("rst_active", active0, 0);
        check_eq("rst_count", cnt0, 0);
        check_eq("rst_count4", cnt4, 0);
        step();
        rst = 1'b0;

        // T1 basic
        en0 = 1'b1;
        push0(8'hA5, 2);
        wait_idle0(100);
        check_eq("t1_count", cnt0, 1);
        check_eq("t1_data_held", txd0, 8'hA5);

        // T2 burst, next pop one cycle after busy falls
        step();
        fall0 = -1;
        chk_gap0 = 1'b1;
        push0(8'h01, 2);
        push0(8'h02, 2);
        push0(8'h03, 2);
        wait_idle0(200);
        chk_gap0 = 1'b0;
        check_eq("t2_count", cnt0, 4);
        check_eq("t2_active", active0, 0);

        // T4 stall in LOAD
        step();
        stall0 = 7;
        push0(8'h5C, 8);
        wait_idle0(100);
        check_eq("t4_count", cnt0, 5);

        // T5 enable dropped in WAIT_DONE
        step();
        push0(8'h11, 2);
        fifo_q0.push_back(8'h22);
        wait_start0(50);
        step();
        step();
        en0 = 1'b0;
        wait_idle0(100);
        p = pops0;
        repeat (20) @(negedge clk);
        check_eq("t5_no_pop_disabled", pops0, p);
        check_eq("t5_fifo_left", fifo_q0.size(), 1);
        check_eq("t5_count", cnt0, 6);
        check_eq("t5_active", active0, 0);

        // T5 reset in WAIT_ACK
        step();
        en0 = 1'b1;
        exp0.push_back('{8'h22, exp_cnt0, 2});
        wait_start0(50);
        step();
        rst = 1'b1;
        en0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t5r_pop", pop0, 0);
        check_eq("t5r_start", start0, 0);
        check_eq("t5r_data", txd0, 0);
        check_eq("t5r_active", active0, 0);
        check_eq("t5r_count", cnt0, 0);
        step();
        rst = 1'b0;
        exp_cnt0 = 0;
        wait_idle0(100);
        step();
        en0 = 1'b1;
        push0(8'h7E, 2);
        wait_idle0(100);
        check_eq("t5r_count_after", cnt0, 1);

`ifdef UART_TX_FLOW_CTRL_EN
        // T6 flow control
        step();
        cts0 = 1'b1;
        repeat (3) step();
        push0(8'h3C, 2);
        p = pops0;
        repeat (10) @(negedge clk);
        check_eq("t6_no_pop_cts_high", pops0, p);
        step();
        cts0 = 1'b0;
        p = cyc;
        wait_start0(50);
        check_eq("t6_pop_delay", last_pop0 - p, 2);
        step();
        cts0 = 1'b1;
        wait_idle0(100);
        check_eq("t6_count", cnt0, 2);
        step();
        cts0 = 1'b0;
`endif

        // T3 gap of 4 cycles, counter wraps at 2 bits
        step();
        en4 = 1'b1;
        push4(8'hC1);
        push4(8'hC2);
        push4(8'hC3);
        push4(8'hC4);
        push4(8'hC5);
        wait_idle4(300);
        check_eq("t3_count_wrapped", cnt4, 1);
        check_eq("t3_active", active4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
